// File: rtl/store_buffer_if.sv
// Core/memory-side signal bundle for the posted-write store buffer.
// The slave modport is the buffer itself; the master modport is the core plus data memory.
interface store_buffer_if #(
    parameter int AW = 2
);
    logic [31:0] CpuAddr;
    logic        CpuRead;
    logic        CpuWrite;
    logic [31:0] CpuWData;
    logic [31:0] CpuRData;
    logic [31:0] MemRAddr;
    logic [31:0] MemRData;
    logic        MemWReq;
    logic [31:0] MemWAddr;
    logic [31:0] MemWData;
    logic        MemWAck;
    logic [AW:0] Count;
    logic        Full;
    logic        Empty;
    logic        Overflow;

    modport master (
        output CpuAddr, CpuRead, CpuWrite, CpuWData, MemRData, MemWAck,
        input  CpuRData, MemRAddr, MemWReq, MemWAddr, MemWData,
        input  Count, Full, Empty, Overflow
    );

    modport slave (
        input  CpuAddr, CpuRead, CpuWrite, CpuWData, MemRData, MemWAck,
        output CpuRData, MemRAddr, MemWReq, MemWAddr, MemWData,
        output Count, Full, Empty, Overflow
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the MEM-stage data port and data memory, draining over
// a req/ack handshake, with youngest-entry store-to-load forwarding on the read path.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic           CLK,
    input  logic           RST,
    store_buffer_if.slave  bus
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [31:0]   addr_r [DEPTH];
    logic [31:0]   data_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          overflow_r;

    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic          fwd_hit_s;
    logic [31:0]   fwd_data_s;
    logic [AW-1:0] idx_s;
    logic          match_s;

    // Occupancy decode and push/pop/drop qualification; a full buffer still accepts a push when the head pops.
    always_comb begin
        empty_s = (count_r == {(AW+1){1'b0}});
        full_s  = (count_r == DEPTH_C);
        pop_s   = !empty_s && bus.MemWAck;
        push_s  = bus.CpuWrite && (!full_s || pop_s);
        drop_s  = bus.CpuWrite && full_s && !pop_s;
    end

    // FIFO storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            overflow_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= 32'h0000_0000;
                data_r[i] <= 32'h0000_0000;
            end
        end else begin
            if (push_s) begin
                addr_r[wr_ptr_r] <= bus.CpuAddr;
                data_r[wr_ptr_r] <= bus.CpuWData;
                wr_ptr_r         <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + (AW+1)'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - (AW+1)'(1);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Walk entries oldest to youngest so the last word-address match is the youngest store.
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = 32'h0000_0000;
        idx_s      = rd_ptr_r;
        match_s    = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s      = rd_ptr_r + AW'(k);
            match_s    = ((AW+1)'(k) < count_r) && (addr_r[idx_s][31:2] == bus.CpuAddr[31:2]);
            fwd_hit_s  = fwd_hit_s | match_s;
            fwd_data_s = match_s ? data_r[idx_s] : fwd_data_s;
        end
    end

    assign bus.CpuRData = (bus.CpuRead && fwd_hit_s) ? fwd_data_s : bus.MemRData;
    assign bus.MemRAddr = bus.CpuAddr;

    // Head entry is only meaningful while the buffer holds data; otherwise drive zeros.
    assign bus.MemWReq  = !empty_s;
    assign bus.MemWAddr = empty_s ? 32'h0000_0000 : addr_r[rd_ptr_r];
    assign bus.MemWData = empty_s ? 32'h0000_0000 : data_r[rd_ptr_r];

    assign bus.Count    = count_r;
    assign bus.Full     = full_s;
    assign bus.Empty    = empty_s;
    assign bus.Overflow = overflow_r;
endmodule

// File: tb/tb_store_buffer.sv
// Directed, table-driven bench for store_buffer: each row drives one cycle of inputs
// and checks the outputs seen before the following rising edge.
module tb_store_buffer;
    logic CLK;
    logic RST;

    store_buffer_if #(.AW(2)) bus ();

    store_buffer #(.DEPTH(4), .AW(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wd;
        logic [31:0] mrd;
        logic        ack;
        logic [31:0] e_rdata;
        int          e_cnt;
        logic [31:0] e_waddr;
        logic [31:0] e_wdata;
        logic        e_ovf;
    } vec_t;

    localparam int NV = 26;
    vec_t tbl [NV];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic vec_t mk(input logic [31:0] addr, input logic rd, input logic wr,
                                input logic [31:0] wd, input logic [31:0] mrd, input logic ack,
                                input logic [31:0] e_rdata, input int e_cnt,
                                input logic [31:0] e_waddr, input logic [31:0] e_wdata,
                                input logic e_ovf);
        vec_t v;
        v.addr = addr; v.rd = rd; v.wr = wr; v.wd = wd; v.mrd = mrd; v.ack = ack;
        v.e_rdata = e_rdata; v.e_cnt = e_cnt; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
        v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int cnt, input logic [31:0] wa,
                             input logic [31:0] wdat, input logic ovf);
        chk({tag, " Count"},    32'(bus.Count),    32'(cnt));
        chk({tag, " Empty"},    32'(bus.Empty),    32'(cnt == 0));
        chk({tag, " Full"},     32'(bus.Full),     32'(cnt == 4));
        chk({tag, " MemWReq"},  32'(bus.MemWReq),  32'(cnt != 0));
        chk({tag, " MemWAddr"}, bus.MemWAddr,      wa);
        chk({tag, " MemWData"}, bus.MemWData,      wdat);
        chk({tag, " Overflow"}, 32'(bus.Overflow), 32'(ovf));
        chk({tag, " MemRAddr"}, bus.MemRAddr,      bus.CpuAddr);
    endtask

    task automatic drive(input logic [31:0] addr, input logic rd, input logic wr,
                         input logic [31:0] wd, input logic [31:0] mrd, input logic ack);
        bus.CpuAddr  = addr;
        bus.CpuRead  = rd;
        bus.CpuWrite = wr;
        bus.CpuWData = wd;
        bus.MemRData = mrd;
        bus.MemWAck  = ack;
    endtask

    initial begin
        //            addr          rd    wr    wd            mrd           ack   e_rdata      cnt e_waddr       e_wdata      ovf
        tbl[0]  = mk(32'h0000_0040, 1'b1, 1'b0, 32'h0,        32'h0000_DEAD, 1'b0, 32'h0000_DEAD, 0, 32'h0,        32'h0,        1'b0);
        tbl[1]  = mk(32'h0000_0100, 1'b0, 1'b1, 32'h11,       32'h55,        1'b0, 32'h55,        0, 32'h0,        32'h0,        1'b0);
        tbl[2]  = mk(32'h0,         1'b0, 1'b0, 32'h0,        32'h0,         1'b0, 32'h0,         1, 32'h100,      32'h11,       1'b0);
        tbl[3]  = mk(32'h0,         1'b0, 1'b0, 32'h0,        32'h0,         1'b0, 32'h0,         1, 32'h100,      32'h11,       1'b0);
        tbl[4]  = mk(32'h0,         1'b0, 1'b0, 32'h0,        32'h0,         1'b0, 32'h0,         1, 32'h100,      32'h11,       1'b0);
        tbl[5]  = mk(32'h0000_0100, 1'b1, 1'b0, 32'h0,        32'h77,        1'b1, 32'h11,        1, 32'h100,      32'h11,       1'b0);
        tbl[6]  = mk(32'h0,         1'b0, 1'b0, 32'h0,        32'h0,         1'b1, 32'h0,         0, 32'h0,        32'h0,        1'b0);
        tbl[7]  = mk(32'h0000_0200, 1'b0, 1'b1, 32'hA,        32'h0,         1'b1, 32'h0,         0, 32'h0,        32'h0,        1'b0);
        tbl[8]  = mk(32'h0000_0204, 1'b0, 1'b1, 32'hB,        32'h0,         1'b0, 32'h0,         1, 32'h200,      32'hA,        1'b0);
        tbl[9]  = mk(32'h0000_0200, 1'b0, 1'b1, 32'hC,        32'h0,         1'b0, 32'h0,         2, 32'h200,      32'hA,        1'b0);
        tbl[10] = mk(32'h0000_0202, 1'b1, 1'b0, 32'h0,        32'h99,        1'b0, 32'hC,         3, 32'h200,      32'hA,        1'b0);
        tbl[11] = mk(32'h0000_0208, 1'b1, 1'b0, 32'h0,        32'h99,        1'b0, 32'h99,        3, 32'h200,      32'hA,        1'b0);
        tbl[12] = mk(32'h0000_0204, 1'b1, 1'b0, 32'h0,        32'h99,        1'b0, 32'hB,         3, 32'h200,      32'hA,        1'b0);
        tbl[13] = mk(32'h0000_0208, 1'b0, 1'b1, 32'hD,        32'h0,         1'b0, 32'h0,         3, 32'h200,      32'hA,        1'b0);
        tbl[14] = mk(32'h0000_0300, 1'b0, 1'b1, 32'h5,        32'h0,         1'b0, 32'h0,         4, 32'h200,      32'hA,        1'b0);
        tbl[15] = mk(32'h0000_0300, 1'b1, 1'b0, 32'h0,        32'h42,        1'b0, 32'h42,        4, 32'h200,      32'hA,        1'b1);
        tbl[16] = mk(32'h0000_030C, 1'b0, 1'b1, 32'h6,        32'h0,         1'b1, 32'h0,         4, 32'h200,      32'hA,        1'b1);
        tbl[17] = mk(32'h0000_0200, 1'b1, 1'b0, 32'h0,        32'h42,        1'b0, 32'hC,         4, 32'h204,      32'hB,        1'b1);
        tbl[18] = mk(32'h0,         1'b0, 1'b0, 32'h0,        32'h0,         1'b1, 32'h0,         4, 32'h204,      32'hB,        1'b1);
        tbl[19] = mk(32'h0,         1'b0, 1'b0, 32'h0,        32'h0,         1'b1, 32'h0,         3, 32'h200,      32'hC,        1'b1);
        tbl[20] = mk(32'h0,         1'b0, 1'b0, 32'h0,        32'h0,         1'b1, 32'h0,         2, 32'h208,      32'hD,        1'b1);
        tbl[21] = mk(32'h0000_030C, 1'b1, 1'b0, 32'h0,        32'h42,        1'b1, 32'h6,         1, 32'h30C,      32'h6,        1'b1);
        tbl[22] = mk(32'h0,         1'b0, 1'b0, 32'h0,        32'h0,         1'b0, 32'h0,         0, 32'h0,        32'h0,        1'b1);
        tbl[23] = mk(32'h0000_0500, 1'b1, 1'b1, 32'h9,        32'h7,         1'b0, 32'h7,         0, 32'h0,        32'h0,        1'b1);
        tbl[24] = mk(32'h0000_0500, 1'b1, 1'b0, 32'h0,        32'h7,         1'b0, 32'h9,         1, 32'h500,      32'h9,        1'b1);
        tbl[25] = mk(32'h0000_0600, 1'b0, 1'b1, 32'h1,        32'h0,         1'b0, 32'h0,         1, 32'h500,      32'h9,        1'b1);

        // Reset with inputs idle, then check the cleared state.
        RST = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk_state("reset", 0, 32'h0, 32'h0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            @(negedge CLK);
            drive(tbl[i].addr, tbl[i].rd, tbl[i].wr, tbl[i].wd, tbl[i].mrd, tbl[i].ack);
            #1;
            chk($sformatf("row%0d CpuRData", i), bus.CpuRData, tbl[i].e_rdata);
            chk_state($sformatf("row%0d", i), tbl[i].e_cnt, tbl[i].e_waddr, tbl[i].e_wdata, tbl[i].e_ovf);
        end

        // Reset with two stores queued and an ack at the reset edge: all abandoned.
        @(negedge CLK);
        drive(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk_state("pre_rst", 2, 32'h500, 32'h9, 1'b1);
        RST = 1'b1;
        bus.MemWAck = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        drive(32'h0000_0500, 1'b1, 1'b0, 32'h0, 32'h1234, 1'b0);
        #1;
        chk_state("post_rst", 0, 32'h0, 32'h0, 1'b0);
        chk("post_rst CpuRData", bus.CpuRData, 32'h1234);

        // Push at edge N, pop at edge N+1: buffer is empty again after N+1.
        @(negedge CLK);
        drive(32'h0000_0700, 1'b0, 1'b1, 32'h77, 32'h0, 1'b0);
        @(negedge CLK);
        drive(32'h0000_0700, 1'b1, 1'b0, 32'h0, 32'h3, 1'b1);
        #1;
        chk("lat MemWReq", 32'(bus.MemWReq), 32'h1);
        chk("lat CpuRData", bus.CpuRData, 32'h77);
        @(negedge CLK);
        drive(32'h0000_0700, 1'b1, 1'b0, 32'h0, 32'h3, 1'b0);
        #1;
        chk_state("lat_done", 0, 32'h0, 32'h0, 1'b0);
        chk("lat_done CpuRData", bus.CpuRData, 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
